rd_addr_seq: RTL and testbench

Read-side address sequencer for the multiplier's digit buffer. It consumes the write address count produced by the write-side counter and issues read addresses 0, 1, 2, … that never overtake the writer. It offers each address to the downstream digit consumer with a valid/ready handshake and marks when synchronous-RAM read data is valid. It sits between the digit RAM read port and the online-multiplier datapath.

---
 rtl/rd_addr_seq.sv | 107 ++++++++++
 tb/tb_rd_addr_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_addr_seq.sv
// rd_addr_seq -- read-side address sequencer for the digit buffer.
//
// Issues read addresses 0,1,2,... to a 1-cycle synchronous RAM. It never
// passes the writer's count, and each address is offered to the consumer
// through a valid/ready handshake.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   start        begin a read pass (only sampled while idle)
//   wr_cnt       number of digits written so far by the write-side counter
//   wr_done      writer finished; wr_cnt is final while high
//   rd_ready     consumer accepts the current address
//   rd_addr      current read address
//   rd_valid     rd_addr holds a written, unread digit
//   ram_re       RAM read enable (a transfer this cycle)
//   data_valid   RAM output holds the digit transferred on the previous cycle
//   data_last    qualifies data_valid: final digit of the pass
//   busy         a pass is in progress
//   done         one-cycle pulse at the end of a pass
//
// Configuration macro RD_ADDR_WRAP_EN:
//   defined   - rd_addr wraps at 2^ADDR_W-1 (circular buffer)
//   undefined - rd_addr stops at 2^ADDR_W-1 and the pass ends after that beat
module rd_addr_seq #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] wr_cnt,
    input  logic              wr_done,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              ram_re,
    output logic              data_valid,
    output logic              data_last,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_READ = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    logic [1:0]        state, state_nx;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] avail;
    logic              xfer;
    logic              at_end;
    logic              tail;

    // Modulo difference: zero means the reader has caught up with the writer.
    assign avail    = wr_cnt - rd_ptr;
    assign rd_valid = (state == S_READ) && (avail != '0);
    assign xfer     = rd_valid & rd_ready;
    assign ram_re   = xfer;
    assign rd_addr  = rd_ptr;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

`ifdef RD_ADDR_WRAP_EN
    assign at_end = 1'b0;
`else
    // The last buffer slot ends the pass even if the writer has not said so.
    assign at_end = (rd_ptr == PTR_MAX);
`endif

    // Final beat: the writer has finished and this is its last digit, or the
    // buffer end is reached in the non-wrapping build.
    assign tail = xfer & ((wr_done & (avail == ONE)) | at_end);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_ARM;
            S_ARM:   state_nx = S_READ;
            // The second term covers an empty tail: the writer finished with
            // nothing left to read, so no beat carries data_last.
            S_READ:  if (tail || (wr_done && (avail == '0))) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            data_valid <= 1'b0;
            data_last  <= 1'b0;
        end else begin
            state      <= state_nx;
            data_valid <= xfer;
            data_last  <= tail;
            if (state == S_IDLE && start)
                rd_ptr <= '0;
            else if (xfer && !at_end)
                rd_ptr <= rd_ptr + ONE;
        end
    end

endmodule

// File: tb/tb_rd_addr_seq.sv
// Testbench for rd_addr_seq. The stimulus issues directed passes and queues the
// beats each pass is expected to deliver. A monitor pops one entry for every
// data_valid and compares the address and the data_last flag.
module tb_rd_addr_seq;

    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] wr_cnt;
    logic              wr_done;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              ram_re;
    logic              data_valid;
    logic              data_last;
    logic              busy;
    logic              done;

    rd_addr_seq #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .wr_cnt     (wr_cnt),
        .wr_done    (wr_done),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .ram_re     (ram_re),
        .data_valid (data_valid),
        .data_last  (data_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              last;
    } exp_t;

    exp_t              sbq[$];
    exp_t              e;
    logic [ADDR_W-1:0] cap_addr = '0;
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int a, input bit l);
        exp_t x;
        x.addr = ADDR_W'(a);
        x.last = l;
        sbq.push_back(x);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: each data_valid must match the next queued beat. The address
    // is the one handed to the RAM on the previous cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: data_valid with empty queue, addr %0d", cap_addr);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_addr", 32'(cap_addr), 32'(e.addr));
                    chk("sb_last", 32'(data_last), 32'(e.last));
                end
            end
            if (ram_re) cap_addr = rd_addr;
        end
    end

    initial begin
        int exp_a;
        int pulses;
        bit rdy, prev_rdy;

        rst_n = 1'b0; start = 1'b0; wr_cnt = '0; wr_done = 1'b0; rd_ready = 1'b0;

        // Reset values.
        smp();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_data_valid", 32'(data_valid), 0);
        chk("rst_done", 32'(done), 0);
        nxt(); rst_n = 1'b1;
        smp();
        chk("idle_busy", 32'(busy), 0);

        // Pass of 5 digits, writer already done, consumer always ready.
        for (int i = 0; i < 5; i++) push(i, i == 4);
        nxt(); start = 1'b1; wr_cnt = 9'd5; wr_done = 1'b1; rd_ready = 1'b1;
        smp(); chk("p5_t_busy", 32'(busy), 0);
        nxt(); start = 1'b0;
        smp(); chk("p5_arm_busy", 32'(busy), 1); chk("p5_arm_valid", 32'(rd_valid), 0);
        for (int i = 0; i < 5; i++) begin
            nxt(); smp();
            chk("p5_valid", 32'(rd_valid), 1);
            chk("p5_addr", 32'(rd_addr), 32'(i));
            chk("p5_ram_re", 32'(ram_re), 1);
            chk("p5_done_early", 32'(done), 0);
        end
        nxt(); smp();
        chk("p5_done", 32'(done), 1);
        chk("p5_last", 32'(data_last), 1);
        chk("p5_dvalid", 32'(data_valid), 1);
        chk("p5_valid_off", 32'(rd_valid), 0);
        nxt(); smp();
        chk("p5_busy_fall", 32'(busy), 0);
        chk("p5_done_pulse", 32'(done), 0);

        // Trickling writer: each new digit is read in the cycle it appears.
        push(0, 1'b0); push(1, 1'b0);
        nxt(); start = 1'b1; wr_cnt = '0; wr_done = 1'b0;
        smp();
        nxt(); start = 1'b0;
        smp();
        nxt(); smp(); chk("tr_empty", 32'(rd_valid), 0);
        for (int k = 1; k <= 2; k++) begin
            nxt(); wr_cnt = ADDR_W'(k);
            smp();
            chk("tr_valid", 32'(rd_valid), 1);
            chk("tr_addr", 32'(rd_addr), 32'(k - 1));
            chk("tr_ram_re", 32'(ram_re), 1);
            for (int j = 0; j < 2; j++) begin
                nxt(); smp();
                chk("tr_gap", 32'(rd_valid), 0);
                chk("tr_not_ahead", 32'(rd_addr <= wr_cnt), 1);
            end
        end
        nxt(); wr_done = 1'b1;
        smp(); chk("tr_done_early", 32'(done), 0);
        nxt(); smp();
        chk("tr_done", 32'(done), 1);
        chk("tr_no_dvalid", 32'(data_valid), 0);
        nxt(); smp(); chk("tr_idle", 32'(busy), 0);

        // Consumer stalls with ready pattern 1,0,0,1.
        for (int i = 0; i < 4; i++) push(i, i == 3);
        nxt(); start = 1'b1; wr_cnt = 9'd4; wr_done = 1'b1; rd_ready = 1'b0;
        smp();
        nxt(); start = 1'b0;
        smp();
        exp_a = 0; pulses = 0; prev_rdy = 1'b0;
        for (int c = 0; c < 8; c++) begin
            rdy = (c % 4 == 0) || (c % 4 == 3);
            nxt(); rd_ready = rdy;
            smp();
            chk("st_addr", 32'(rd_addr), 32'(exp_a));
            chk("st_ram_re", 32'(ram_re), 32'(rdy));
            chk("st_dvalid", 32'(data_valid), 32'(prev_rdy));
            if (ram_re) pulses++;
            if (rdy) exp_a++;
            prev_rdy = rdy;
        end
        nxt(); rd_ready = 1'b1;
        smp();
        chk("st_done", 32'(done), 1);
        chk("st_last", 32'(data_last), 1);
        chk("st_pulses", 32'(pulses), 4);
        nxt(); smp(); chk("st_idle", 32'(busy), 0);

        // Writer finished with nothing written: start, ARM, READ, DONE.
        nxt(); start = 1'b1; wr_cnt = '0; wr_done = 1'b1;
        smp();
        nxt(); start = 1'b0;
        smp(); chk("em_arm", 32'(busy), 1);
        nxt(); smp();
        chk("em_read_valid", 32'(rd_valid), 0);
        chk("em_read_done", 32'(done), 0);
        nxt(); smp();
        chk("em_done", 32'(done), 1);
        chk("em_dvalid", 32'(data_valid), 0);
        chk("em_last", 32'(data_last), 0);
        nxt(); smp(); chk("em_idle", 32'(busy), 0);

        // Run through the whole buffer: wr_cnt goes to 511, then 0 (512 written).
        for (int i = 0; i < 511; i++) push(i, 1'b0);
`ifdef RD_ADDR_WRAP_EN
        push(511, 1'b0); push(0, 1'b0); push(1, 1'b0); push(2, 1'b1);
`else
        push(511, 1'b1);
`endif
        nxt(); start = 1'b1; wr_cnt = '0; wr_done = 1'b0; rd_ready = 1'b1;
        smp();
        nxt(); start = 1'b0;
        smp();
        for (int i = 0; i < 511; i++) begin
            nxt(); wr_cnt = 9'd511;
            smp(); chk("wr_addr", 32'(rd_addr), 32'(i));
        end
        nxt(); wr_cnt = '0;
        smp();
        chk("wr_addr511", 32'(rd_addr), 511);
        chk("wr_valid511", 32'(rd_valid), 1);
        nxt(); smp();
`ifdef RD_ADDR_WRAP_EN
        chk("wr_wrap_addr", 32'(rd_addr), 0);
        chk("wr_wrap_valid", 32'(rd_valid), 0);
        chk("wr_wrap_done", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            nxt(); wr_cnt = 9'd3; wr_done = 1'b1;
            smp(); chk("wr_wrap_addr2", 32'(rd_addr), 32'(i));
        end
        nxt(); smp();
        chk("wr_wrap_end", 32'(done), 1);
        chk("wr_wrap_last", 32'(data_last), 1);
`else
        chk("wr_sat_done", 32'(done), 1);
        chk("wr_sat_last", 32'(data_last), 1);
        chk("wr_sat_dvalid", 32'(data_valid), 1);
`endif
        nxt(); smp(); chk("wr_idle", 32'(busy), 0);

        // Asynchronous reset in the middle of a pass at rd_addr 7.
        for (int i = 0; i < 7; i++) push(i, 1'b0);
        nxt(); start = 1'b1; wr_cnt = 9'd20; wr_done = 1'b0;
        smp();
        nxt(); start = 1'b0;
        smp();
        for (int i = 0; i < 7; i++) begin
            nxt(); smp();
        end
        nxt(); smp();
        chk("ar_addr7", 32'(rd_addr), 7);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_addr", 32'(rd_addr), 0);
        chk("ar_valid", 32'(rd_valid), 0);
        chk("ar_ram_re", 32'(ram_re), 0);
        chk("ar_dvalid", 32'(data_valid), 0);
        chk("ar_last", 32'(data_last), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_done", 32'(done), 0);
        nxt(); smp();
        nxt(); rst_n = 1'b1;
        smp();
        chk("ar_post_busy", 32'(busy), 0);
        chk("ar_post_addr", 32'(rd_addr), 0);
        chk("ar_post_done", 32'(done), 0);
        nxt(); smp();

        chk("sb_drained", 32'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
